// File: rtl/iq_alloc_pkg.sv
// Shared sizing, issue-port payload and helpers for the issue-queue entry allocator.
package iq_alloc_pkg;

  localparam int unsigned IQ_ENT_NUM = 16;
  localparam int unsigned IQ_ENT_SEL = 4;
  localparam int unsigned CNT_W      = IQ_ENT_SEL + 1;

  typedef struct packed {
    logic                  v;
    logic [IQ_ENT_SEL-1:0] idx;
  } issue_port_t;

  function automatic logic [CNT_W-1:0] popcnt(input logic [IQ_ENT_NUM-1:0] vec);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < int'(IQ_ENT_NUM); i++) begin
      cnt = cnt + CNT_W'(vec[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/iq_pick2.sv
// Combinational finder for the lowest and second-lowest set bits of a free-entry bitmap.
module iq_pick2
  import iq_alloc_pkg::*;
(
  input  logic [IQ_ENT_NUM-1:0] free_vec,
  output logic [IQ_ENT_SEL-1:0] f0,
  output logic [IQ_ENT_SEL-1:0] f1,
  output logic                  f0_v,
  output logic                  f1_v
);

  always_comb begin
    f0   = '0;
    f1   = '0;
    f0_v = 1'b0;
    f1_v = 1'b0;
    for (int i = 0; i < int'(IQ_ENT_NUM); i++) begin
      if (free_vec[i]) begin
        if (!f0_v) begin
          f0   = IQ_ENT_SEL'(i);
          f0_v = 1'b1;
        end else if (!f1_v) begin
          f1   = IQ_ENT_SEL'(i);
          f1_v = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/iq_alloc.sv
// Dispatch-stage allocator: hands out up to two free IQ entries per cycle and
// reclaims entries on issue and on misprediction flush.
module iq_alloc
  import iq_alloc_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  invalid1,
  input  logic                  invalid2,
  input  logic                  stall_ext,
  input  logic                  prmiss,
  input  logic [IQ_ENT_NUM-1:0] kill_vec,
  input  logic                  issue_v_1,
  input  logic                  issue_v_2,
  input  logic [IQ_ENT_SEL-1:0] issue_idx_1,
  input  logic [IQ_ENT_SEL-1:0] issue_idx_2,
  output logic [IQ_ENT_SEL-1:0] iq_entry_num_1,
  output logic [IQ_ENT_SEL-1:0] iq_entry_num_2,
  output logic                  stall_DP,
  output logic [CNT_W-1:0]      free_cnt,
  output logic [IQ_ENT_NUM-1:0] busy_vec,
  output logic                  err
);

  logic [IQ_ENT_NUM-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]      free_cnt_q, free_cnt_d;
  logic                  err_q, err_d;

  logic [IQ_ENT_SEL-1:0] f0, f1;
  logic                  f0_v, f1_v;
  logic [1:0]            need;
  logic                  alloc_en;
  logic [IQ_ENT_NUM-1:0] alloc_mask, clr_mask, freed_mask;
  issue_port_t           iss1, iss2;

  assign iss1 = '{v: issue_v_1, idx: issue_idx_1};
  assign iss2 = '{v: issue_v_2, idx: issue_idx_2};

  iq_pick2 u_pick2 (
    .free_vec (~busy_q),
    .f0       (f0),
    .f1       (f1),
    .f0_v     (f0_v),
    .f1_v     (f1_v)
  );

  // Pick and stall decision; slot 2 packs onto f0 when slot 1 is empty.
  always_comb begin
    iq_entry_num_1 = f0_v ? f0 : '0;
    iq_entry_num_2 = invalid1 ? iq_entry_num_1 : (f1_v ? f1 : '0);
    need           = {1'b0, ~invalid1} + {1'b0, ~invalid2};
    stall_DP       = stall_ext | prmiss | (CNT_W'(need) > free_cnt_q);
    alloc_en       = ~stall_DP;
  end

  // Next state: frees are never bypassed, so allocation only touches entries free now.
  always_comb begin
    alloc_mask = '0;
    clr_mask   = '0;
    if (alloc_en && !invalid1) alloc_mask[iq_entry_num_1] = 1'b1;
    if (alloc_en && !invalid2) alloc_mask[iq_entry_num_2] = 1'b1;
    if (iss1.v) clr_mask[iss1.idx] = 1'b1;
    if (iss2.v) clr_mask[iss2.idx] = 1'b1;
    if (prmiss) clr_mask = clr_mask | kill_vec;
    freed_mask = busy_q & clr_mask;
    busy_d     = (busy_q & ~clr_mask) | alloc_mask;
    free_cnt_d = free_cnt_q - popcnt(alloc_mask) + popcnt(freed_mask);
    err_d      = err_q
               | (iss1.v & ~busy_q[iss1.idx])
               | (iss2.v & ~busy_q[iss2.idx])
               | (iss1.v & iss2.v & (iss1.idx == iss2.idx));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q     <= '0;
      free_cnt_q <= CNT_W'(IQ_ENT_NUM);
      err_q      <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      free_cnt_q <= free_cnt_d;
      err_q      <= err_d;
    end
  end

  assign busy_vec = busy_q;
  assign free_cnt = free_cnt_q;
  assign err      = err_q;

endmodule

// File: tb/tb_iq_alloc.sv
// Self-checking bench for iq_alloc: vector table plus a scoreboard of post-edge state.
module tb_iq_alloc;

  logic        clk = 1'b0;
  logic        reset;
  logic        invalid1, invalid2, stall_ext, prmiss;
  logic [15:0] kill_vec;
  logic        issue_v_1, issue_v_2;
  logic [3:0]  issue_idx_1, issue_idx_2;
  logic [3:0]  iq_entry_num_1, iq_entry_num_2;
  logic        stall_DP;
  logic [4:0]  free_cnt;
  logic [15:0] busy_vec;
  logic        err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  iq_alloc dut (
    .clk            (clk),
    .reset          (reset),
    .invalid1       (invalid1),
    .invalid2       (invalid2),
    .stall_ext      (stall_ext),
    .prmiss         (prmiss),
    .kill_vec       (kill_vec),
    .issue_v_1      (issue_v_1),
    .issue_v_2      (issue_v_2),
    .issue_idx_1    (issue_idx_1),
    .issue_idx_2    (issue_idx_2),
    .iq_entry_num_1 (iq_entry_num_1),
    .iq_entry_num_2 (iq_entry_num_2),
    .stall_DP       (stall_DP),
    .free_cnt       (free_cnt),
    .busy_vec       (busy_vec),
    .err            (err)
  );

  typedef struct {
    logic        rst_before;
    logic        inv1, inv2, sext, pm;
    logic [15:0] kill;
    logic        iv1;
    logic [3:0]  idx1;
    logic        iv2;
    logic [3:0]  idx2;
    logic [3:0]  e_n1, e_n2;
    logic        e_stall;
    logic [15:0] e_busy;
    logic [4:0]  e_free;
    logic        e_err;
  } vec_t;

  typedef struct {
    int          id;
    logic [15:0] busy;
    logic [4:0]  free;
    logic        err;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  function automatic vec_t mk(logic rb, logic i1, logic i2, logic se, logic pm,
                              logic [15:0] kl, logic v1, logic [3:0] x1,
                              logic v2, logic [3:0] x2, logic [3:0] n1,
                              logic [3:0] n2, logic st, logic [15:0] bz,
                              logic [4:0] fc, logic er);
    vec_t v;
    v.rst_before = rb; v.inv1 = i1; v.inv2 = i2; v.sext = se; v.pm = pm;
    v.kill = kl; v.iv1 = v1; v.idx1 = x1; v.iv2 = v2; v.idx2 = x2;
    v.e_n1 = n1; v.e_n2 = n2; v.e_stall = st; v.e_busy = bz; v.e_free = fc;
    v.e_err = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    invalid1 = 1'b1; invalid2 = 1'b1; stall_ext = 1'b0; prmiss = 1'b0;
    kill_vec = '0; issue_v_1 = 1'b0; issue_v_2 = 1'b0;
    issue_idx_1 = '0; issue_idx_2 = '0;
  endtask

  // Reset held across one posedge; released at a negedge.
  task automatic do_reset();
    idle_inputs();
    invalid1 = 1'b0; invalid2 = 1'b0; stall_ext = 1'b1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_busy", 32'(busy_vec), 32'h0);
    chk("rst_free", 32'(free_cnt), 32'd16);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_n1", 32'(iq_entry_num_1), 32'd0);
    chk("rst_n2", 32'(iq_entry_num_2), 32'd1);
    chk("rst_stall", 32'(stall_DP), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
  endtask

  task automatic apply(input int id, input vec_t v);
    exp_t e;
    invalid1 = v.inv1; invalid2 = v.inv2; stall_ext = v.sext; prmiss = v.pm;
    kill_vec = v.kill; issue_v_1 = v.iv1; issue_idx_1 = v.idx1;
    issue_v_2 = v.iv2; issue_idx_2 = v.idx2;
    #1;
    chk($sformatf("v%0d_n1", id), 32'(iq_entry_num_1), 32'(v.e_n1));
    chk($sformatf("v%0d_n2", id), 32'(iq_entry_num_2), 32'(v.e_n2));
    chk($sformatf("v%0d_stall", id), 32'(stall_DP), 32'(v.e_stall));
    sb.push_back('{id: id, busy: v.e_busy, free: v.e_free, err: v.e_err});
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL v%0d_sb: got empty scoreboard expected entry", id);
    end else begin
      e = sb.pop_front();
      chk($sformatf("v%0d_busy", e.id), 32'(busy_vec), 32'(e.busy));
      chk($sformatf("v%0d_free", e.id), 32'(free_cnt), 32'(e.free));
      chk($sformatf("v%0d_err", e.id), 32'(err), 32'(e.err));
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();

    // Fill: pairs (0,1)..(14,15), then the full-queue corners.
    for (int k = 0; k < 8; k++) begin
      tbl.push_back(mk(k == 0, 0, 0, 0, 0, '0, 0, 0, 0, 0,
                       4'(2*k), 4'(2*k+1), 0,
                       16'((32'd1 << (2*k+2)) - 1), 5'(14 - 2*k), 0));
    end
    tbl.push_back(mk(0, 0, 0, 0, 0, '0, 0, 0, 0, 0, 0, 0, 1, 16'hFFFF, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, '0, 0, 0, 0, 0, 0, 0, 0, 16'hFFFF, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, '0, 1, 5, 0, 0, 0, 0, 1, 16'hFFDF, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, '0, 0, 0, 0, 0, 5, 0, 1, 16'hFFDF, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, '0, 0, 0, 0, 0, 5, 0, 0, 16'hFFFF, 0, 0));
    // Flush with concurrent issue; no allocation while prmiss is high.
    tbl.push_back(mk(0, 0, 0, 0, 1, 16'hF0F0, 1, 0, 0, 0, 0, 0, 1, 16'h0F0E, 9, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, '0, 0, 0, 0, 0, 0, 0, 0, 16'h0F0E, 9, 0));
    // Duplicate issue index: one entry freed, sticky error.
    tbl.push_back(mk(0, 1, 1, 0, 0, '0, 1, 3, 1, 3, 0, 0, 0, 16'h0F06, 10, 1));
    tbl.push_back(mk(0, 1, 1, 0, 0, '0, 0, 0, 0, 0, 0, 0, 0, 16'h0F06, 10, 1));
    // Packing after reset, external stall, and issue to a free entry.
    tbl.push_back(mk(1, 0, 1, 0, 0, '0, 0, 0, 0, 0, 0, 1, 0, 16'h0001, 15, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, '0, 0, 0, 0, 0, 1, 1, 0, 16'h0003, 14, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, '0, 0, 0, 0, 0, 2, 3, 1, 16'h0003, 14, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, '0, 1, 9, 0, 0, 2, 2, 0, 16'h0003, 14, 1));
    // Build 0x00FF ahead of the asynchronous reset sequence.
    tbl.push_back(mk(1, 0, 0, 0, 0, '0, 0, 0, 0, 0, 0, 1, 0, 16'h0003, 14, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, '0, 0, 0, 0, 0, 2, 3, 0, 16'h000F, 12, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, '0, 0, 0, 0, 0, 4, 5, 0, 16'h003F, 10, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, '0, 0, 0, 0, 0, 6, 7, 0, 16'h00FF, 8, 0));

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst_before) do_reset();
      apply(i, tbl[i]);
    end

    // Asynchronous reset mid-cycle clears state before the next edge.
    #2;
    reset = 1'b0;
    #1;
    chk("async_busy", 32'(busy_vec), 32'h0);
    chk("async_free", 32'(free_cnt), 32'd16);
    chk("async_n1", 32'(iq_entry_num_1), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL sb_drain: got %0d expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/iq_alloc.md
Name: iq_alloc

Overview:
- Issue-queue entry allocator that sits directly upstream of the issue queue, at the dispatch stage.
- Tracks a busy bitmap of IQ entries and picks up to two free entry numbers per cycle (iq_entry_num_1/2) for dispatching instructions.
- Asserts stall_DP when the free entries cannot cover the request.
- Reclaims entries when they issue and when a branch misprediction kills wrong-path entries.

Parameters:
- IQ_ENT_NUM, 16, number of issue-queue entries.
- IQ_ENT_SEL, 4, index width, equal to log2(IQ_ENT_NUM).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- invalid1  in  1  dispatch slot 1 carries no instruction
- invalid2  in  1  dispatch slot 2 carries no instruction
- stall_ext  in  1  stall raised by another dispatch resource (ROB/LSQ full)
- prmiss  in  1  branch misprediction this cycle
- kill_vec  in  IQ_ENT_NUM  entries to free on prmiss, one bit per entry
- issue_v_1, issue_v_2  in  1  an entry issued on select port 1/2
- issue_idx_1, issue_idx_2  in  IQ_ENT_SEL  index of the issued entry
- iq_entry_num_1  out  IQ_ENT_SEL  entry assigned to slot 1
- iq_entry_num_2  out  IQ_ENT_SEL  entry assigned to slot 2
- stall_DP  out  1  dispatch must hold this cycle
- free_cnt  out  IQ_ENT_SEL+1  number of free entries (registered)
- busy_vec  out  IQ_ENT_NUM  registered busy bitmap
- err  out  1  sticky protocol error flag

Behaviour:
- Reset (reset=0, asynchronous):
  - busy_vec=0, free_cnt=IQ_ENT_NUM, err=0.
  - Outputs: iq_entry_num_1=0, iq_entry_num_2=1, stall_DP=stall_ext.
- Entry pick (combinational, from registered busy_vec):
  - f0 = lowest free index; f1 = second-lowest free index.
  - iq_entry_num_1 = f0.
  - iq_entry_num_2 = f1 if invalid1=0, else f0 (packing).
  - If no free entry exists, the index outputs are don't-care and 0 is driven.
- Demand: need = (~invalid1) + (~invalid2), range 0..2.
- stall_DP = stall_ext | prmiss | (need > free_cnt).
- Allocation: committed at the clock edge only when stall_DP=0; sets busy for each valid slot's entry.
  - All-or-nothing: both slots allocate or neither does.
  - No partial allocation.
- Issue free: for each issue_v_k=1, clear busy[issue_idx_k] at the clock edge.
  - Applies regardless of stall_DP or prmiss.
- Flush: when prmiss=1, clear busy[i] for every kill_vec[i]=1 in the same edge; no allocation that cycle.
- Same-cycle timing:
  - Frees are not bypassed: an entry freed at edge N is pickable from cycle N+1.
  - Allocation and frees never target the same entry, because only free entries are picked.
- free_cnt update: next = free_cnt − allocated + (number of distinct entries whose busy bit goes 1→0).
  - Computed by popcount of the freed mask, so duplicate frees count once.
  - Invariant: free_cnt equals IQ_ENT_NUM − popcount(busy_vec) at all times.
- err is set, and held until reset, if any of these occur:
  - issue_v_k=1 targets an already-free entry.
  - issue_v_1 and issue_v_2 both assert with equal indices.
- Boundaries:
  - Full (free_cnt=0) with need≥1 stalls.
  - free_cnt=1 with need=2 stalls, and no entry is allocated.
  - need=0 never stalls on capacity.
  - Reset asserted mid-operation clears everything immediately; state is not preserved.

Decomposition:
- constants.vh carries IQ_ENT_NUM and IQ_ENT_SEL; the issue queue shares them.
- One sub-module, iq_pick2: combinational first-two-free finder.
  - Input: the inverted busy bitmap.
  - Outputs: f0, f1, and valid bits for each.

Test Plan:
- Reset, then invalid1=invalid2=0 for 8 cycles -> entries (0,1),(2,3)…(14,15) allocated; free_cnt steps 16,14,…,2,0; cycle 9 shows stall_DP=1.
- Full queue; issue_v_1=1 idx=5 -> next cycle free_cnt=1, iq_entry_num_1=5; need=2 stalls; invalid2=1 allocates 5 and free_cnt=0.
- invalid1=1, invalid2=0 with busy_vec=0x0001 -> iq_entry_num_2=1, only entry 1 is set busy.
- Busy 0xFFFF, prmiss=1, kill_vec=0xF0F0, issue_v_1 idx=0 -> busy_vec=0x0F0E, free_cnt=9; no allocation that cycle.
- issue_v_1=issue_v_2=1, both idx=3 (busy) -> err=1 and stays 1; free_cnt increases by exactly 1.
- Assert reset=0 asynchronously mid-cycle while busy=0x00FF -> busy_vec=0, free_cnt=16 before the next edge.
